psum_accum_buffer: RTL and testbench

- Output-side partial-sum buffer, directly downstream of the PE array controller and PE array.
- Captures the 16-lane 32-bit column sums from the bottom of the array using the controller's delayed accumulate enable, clear and address. Performs read-modify-write accumulation per output pixel.
- After a convolution completes, drains every pixel through bias add, optional ReLU, rounding right-shift and int8 saturation onto a ready/valid stream.

---
 rtl/psum_accum_buffer_if.sv | 45 ++++
 rtl/psum_accum_buffer.sv | 223 ++++++++++++++++++++++
 tb/tb_psum_accum_buffer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_accum_buffer_if.sv
// Bundles the accumulate, drain-control and output-stream signals of the
// partial-sum buffer. The upstream side (controller, PE array, consumer)
// takes the master view; the buffer takes the slave view.
interface psum_accum_buffer_if #(
    parameter int ARRAY_DIM = 16,
    parameter int ACC_W     = 32,
    parameter int OUT_W     = 8,
    parameter int AW        = 10
);
    // accumulate side
    logic                        acc_enable;
    logic                        acc_clear;
    logic [AW-1:0]               acc_addr;
    logic [ARRAY_DIM*ACC_W-1:0]  pe_acc_out;

    // drain control and requant configuration
    logic                        drain_start;
    logic [AW:0]                 drain_count;
    logic [4:0]                  shift;
    logic                        relu_en;
    logic [ARRAY_DIM*ACC_W-1:0]  bias;

    // output stream and status
    logic                        out_valid;
    logic                        out_ready;
    logic [AW-1:0]               out_addr;
    logic [ARRAY_DIM*OUT_W-1:0]  out_data;
    logic                        busy;
    logic                        drain_done;
    logic                        acc_conflict;

    modport master (
        output acc_enable, acc_clear, acc_addr, pe_acc_out,
        output drain_start, drain_count, shift, relu_en, bias,
        output out_ready,
        input  out_valid, out_addr, out_data, busy, drain_done, acc_conflict
    );

    modport slave (
        input  acc_enable, acc_clear, acc_addr, pe_acc_out,
        input  drain_start, drain_count, shift, relu_en, bias,
        input  out_ready,
        output out_valid, out_addr, out_data, busy, drain_done, acc_conflict
    );
endinterface

// File: rtl/psum_accum_buffer.sv
// Output-side partial-sum buffer. Accumulates 16-lane column sums per output
// pixel with read-modify-write, then drains every entry through bias add,
// optional ReLU, rounding right-shift and int8 saturation onto a ready/valid
// stream.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | accepting accumulates, waiting for drain_start
// LOAD   | requantize mem[rd_ptr] into the output registers, raise out_valid
// SEND   | hold the beat until out_ready; then next entry or finish
module psum_accum_buffer #(
    parameter int ARRAY_DIM = 16,
    parameter int DEPTH     = 1024,
    parameter int ACC_W     = 32,
    parameter int OUT_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    psum_accum_buffer_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int ROW_W = ARRAY_DIM * ACC_W;
    localparam int OUT_ROW_W = ARRAY_DIM * OUT_W;
    localparam int RQ_W  = ACC_W + 2;

    localparam logic signed [RQ_W-1:0] SAT_HI = RQ_W'(2**(OUT_W-1) - 1);
    localparam logic signed [RQ_W-1:0] SAT_LO = RQ_W'(-(2**(OUT_W-1)));
    localparam logic signed [RQ_W-1:0] RQ_ONE = RQ_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Storage is deliberately left out of reset so partial sums survive rst_n.
    logic [ROW_W-1:0]     r_mem [DEPTH];

    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic [4:0]           r_shift;
    logic                 r_relu;
    logic                 r_out_valid;
    logic [AW-1:0]        r_out_addr;
    logic [OUT_ROW_W-1:0] r_out_data;
    logic                 r_drain_done;
    logic                 r_conflict;

    logic                 w_busy;
    logic                 w_acc_fire;
    logic [ROW_W-1:0]     w_rmw_old;
    logic [ROW_W-1:0]     w_rmw_new;
    logic [ROW_W-1:0]     w_rd_data;
    logic [OUT_ROW_W-1:0] w_rq_data;
    logic                 w_is_last;
    logic                 w_start;
    logic                 w_zero_done;
    logic                 w_load;
    logic                 w_hs;
    logic                 w_last;

    // Per-lane requant in 34-bit signed: the two extra bits hold the sum of a
    // 32-bit value, a 32-bit bias and the rounding constant without overflow.
    function automatic logic [OUT_W-1:0] f_requant(
        input logic [ACC_W-1:0] acc,
        input logic [ACC_W-1:0] b,
        input logic             relu,
        input logic [4:0]       sh
    );
        logic signed [RQ_W-1:0] v;
        logic signed [RQ_W-1:0] rnd;
        v = $signed({{2{acc[ACC_W-1]}}, acc}) + $signed({{2{b[ACC_W-1]}}, b});
        if (relu && v[RQ_W-1]) begin
            v = '0;
        end
        if (sh != 5'd0) begin
            rnd = RQ_ONE <<< (sh - 5'd1);
            v   = (v + rnd) >>> sh;
        end
        if (v > SAT_HI) begin
            v = SAT_HI;
        end else if (v < SAT_LO) begin
            v = SAT_LO;
        end
        return v[OUT_W-1:0];
    endfunction

    assign w_busy     = (r_state != S_IDLE);
    assign w_acc_fire = bus.acc_enable && !w_busy;
    // Asynchronous read keeps RMW hazard-free: a write lands at the edge and
    // the very next cycle's read already sees it.
    assign w_rmw_old  = r_mem[bus.acc_addr];
    assign w_rd_data  = r_mem[r_rd_ptr];
    assign w_is_last  = (({1'b0, r_rd_ptr} + (AW+1)'(1)) == r_count);

    // Lane-wise overwrite or wrapping add for the accumulate write-back.
    always_comb begin
        w_rmw_new = '0;
        for (int i = 0; i < ARRAY_DIM; i++) begin
            if (bus.acc_clear) begin
                w_rmw_new[i*ACC_W +: ACC_W] = bus.pe_acc_out[i*ACC_W +: ACC_W];
            end else begin
                w_rmw_new[i*ACC_W +: ACC_W] = w_rmw_old[i*ACC_W +: ACC_W]
                                            + bus.pe_acc_out[i*ACC_W +: ACC_W];
            end
        end
    end

    // Requantize the entry currently addressed by the drain pointer.
    always_comb begin
        w_rq_data = '0;
        for (int i = 0; i < ARRAY_DIM; i++) begin
            w_rq_data[i*OUT_W +: OUT_W] = f_requant(w_rd_data[i*ACC_W +: ACC_W],
                                                    bus.bias[i*ACC_W +: ACC_W],
                                                    r_relu, r_shift);
        end
    end

    // Accumulate write port; blocked while a drain owns the buffer.
    always_ff @(posedge clk) begin
        if (w_acc_fire) begin
            r_mem[bus.acc_addr] <= w_rmw_new;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_zero_done = 1'b0;
        w_load      = 1'b0;
        w_hs        = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.drain_start) begin
                    if (bus.drain_count == '0) begin
                        w_zero_done = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (bus.out_ready) begin
                    w_hs = 1'b1;
                    if (w_is_last) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Drain datapath: config latch, pointer, output beat registers, status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_shift      <= '0;
            r_relu       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_addr   <= '0;
            r_out_data   <= '0;
            r_drain_done <= 1'b0;
            r_conflict   <= 1'b0;
        end else begin
            r_drain_done <= w_zero_done || w_last;
            if (w_start) begin
                r_count  <= bus.drain_count;
                r_shift  <= bus.shift;
                r_relu   <= bus.relu_en;
                r_rd_ptr <= '0;
            end
            if (w_load) begin
                r_out_data  <= w_rq_data;
                r_out_addr  <= r_rd_ptr;
                r_out_valid <= 1'b1;
            end
            // valid drops on every handshake so a beat can't be accepted twice
            if (w_hs) begin
                r_out_valid <= 1'b0;
                if (!w_last) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
            if (bus.acc_enable && w_busy) begin
                r_conflict <= 1'b1;
            end
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.out_addr     = r_out_addr;
    assign bus.out_data     = r_out_data;
    assign bus.busy         = w_busy;
    assign bus.drain_done   = r_drain_done;
    assign bus.acc_conflict = r_conflict;

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Directed bench for psum_accum_buffer: a behavioural memory model feeds a
// scoreboard of expected beats, which are popped as the DUT streams them out.
module tb_psum_accum_buffer;
    localparam int LANES = 16;

    typedef struct packed {
        logic [9:0]   addr;
        logic [127:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psum_accum_buffer_if bus ();

    psum_accum_buffer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    beat_t        sb_q[$];
    logic [511:0] m_mem [1024];
    logic [127:0] cap [1024];
    int           n_assert = 0;
    int           n_fail = 0;
    logic [511:0] cur_bias;
    bit           cur_relu;
    int           cur_shift;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] splat(input int v);
        logic [511:0] d;
        for (int i = 0; i < LANES; i++) d[i*32 +: 32] = v;
        return d;
    endfunction

    function automatic logic [7:0] tb_rq(input logic [31:0] m, input logic [31:0] b,
                                         input bit relu, input int sh);
        longint v;
        v = longint'($signed(m)) + longint'($signed(b));
        if (relu && v < 0) v = 0;
        if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
        return v[7:0];
    endfunction

    function automatic logic [127:0] rq_entry(input int a);
        logic [127:0] r;
        for (int i = 0; i < LANES; i++)
            r[i*8 +: 8] = tb_rq(m_mem[a][i*32 +: 32], cur_bias[i*32 +: 32], cur_relu, cur_shift);
        return r;
    endfunction

    task automatic m_acc(input int a, input bit clr, input logic [511:0] d);
        for (int i = 0; i < LANES; i++) begin
            if (clr) m_mem[a][i*32 +: 32] = d[i*32 +: 32];
            else     m_mem[a][i*32 +: 32] = m_mem[a][i*32 +: 32] + d[i*32 +: 32];
        end
    endtask

    task automatic set_cfg(input logic [511:0] b, input bit relu, input int sh);
        cur_bias = b; cur_relu = relu; cur_shift = sh;
        bus.bias = b; bus.relu_en = relu; bus.shift = 5'(sh);
    endtask

    task automatic acc_beat(input int a, input bit clr, input logic [511:0] d);
        bus.acc_enable = 1'b1;
        bus.acc_clear  = clr;
        bus.acc_addr   = 10'(a);
        bus.pe_acc_out = d;
        m_acc(a, clr, d);
        tick();
    endtask

    task automatic acc_idle();
        bus.acc_enable = 1'b0;
        bus.acc_clear  = 1'b0;
    endtask

    task automatic drain(input int cnt, input int stall_beat, input int stall_cyc,
                         input int abort_at, input bit poke, input bit pre_acc,
                         input int pa, input logic [511:0] pd);
        beat_t e;
        int    beat;
        int    since;
        beat = 0;
        if (pre_acc) m_acc(pa, 1'b0, pd);
        for (int i = 0; i < cnt; i++) begin
            e.addr = 10'(i);
            e.data = rq_entry(i);
            sb_q.push_back(e);
        end
        bus.drain_start = 1'b1;
        bus.drain_count = 11'(cnt);
        if (pre_acc) begin
            bus.acc_enable = 1'b1; bus.acc_clear = 1'b0;
            bus.acc_addr = 10'(pa); bus.pe_acc_out = pd;
        end
        tick();
        bus.drain_start = 1'b0;
        acc_idle();
        since = 1;
        if (cnt == 0) begin
            chk("zero_done_pulse", 128'(bus.drain_done), 128'(1));
            chk("zero_no_valid", 128'(bus.out_valid), 128'(0));
            chk("zero_not_busy", 128'(bus.busy), 128'(0));
            tick();
            chk("zero_done_low", 128'(bus.drain_done), 128'(0));
            chk("zero_no_valid2", 128'(bus.out_valid), 128'(0));
            return;
        end
        chk("busy_after_start", 128'(bus.busy), 128'(1));
        if (poke) begin
            bus.acc_enable = 1'b1; bus.acc_clear = 1'b1; bus.acc_addr = 10'd0;
            bus.pe_acc_out = ~512'd0;
            bus.drain_start = 1'b1; bus.drain_count = 11'd1;
            tick();
            since++;
            acc_idle();
            bus.drain_start = 1'b0;
        end
        while (sb_q.size() > 0) begin
            while (!bus.out_valid && since < 20) begin
                tick();
                since++;
            end
            chk("beat_valid", 128'(bus.out_valid), 128'(1));
            if (!bus.out_valid) begin
                sb_q.delete();
                return;
            end
            chk(beat == 0 ? "first_latency" : "beat_spacing", 128'(since), 128'(2));
            e = sb_q.pop_front();
            if (beat == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", 128'(bus.out_valid), 128'(0));
                chk("rst_addr", 128'(bus.out_addr), 128'(0));
                chk("rst_data", bus.out_data, 128'(0));
                chk("rst_busy", 128'(bus.busy), 128'(0));
                tick();
                chk("rst_no_done", 128'(bus.drain_done), 128'(0));
                rst_n = 1'b1;
                tick();
                chk("rst_no_done2", 128'(bus.drain_done), 128'(0));
                sb_q.delete();
                return;
            end
            if (beat == stall_beat) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    tick();
                    chk("stall_valid", 128'(bus.out_valid), 128'(1));
                    chk("stall_addr", 128'(bus.out_addr), 128'(e.addr));
                    chk("stall_data", bus.out_data, e.data);
                end
            end
            chk("beat_addr", 128'(bus.out_addr), 128'(e.addr));
            chk("beat_data", bus.out_data, e.data);
            cap[e.addr] = bus.out_data;
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            since = 1;
            beat++;
            if (sb_q.size() > 0) begin
                chk("gap_valid_low", 128'(bus.out_valid), 128'(0));
                chk("gap_no_done", 128'(bus.drain_done), 128'(0));
            end
        end
        chk("done_pulse", 128'(bus.drain_done), 128'(1));
        chk("done_valid_low", 128'(bus.out_valid), 128'(0));
        chk("done_not_busy", 128'(bus.busy), 128'(0));
        tick();
        chk("done_one_cycle", 128'(bus.drain_done), 128'(0));
    endtask

    initial begin
        logic [511:0] d;
        logic [511:0] b;
        bus.acc_enable = 1'b0; bus.acc_clear = 1'b0; bus.acc_addr = '0;
        bus.pe_acc_out = '0; bus.drain_start = 1'b0; bus.drain_count = '0;
        bus.out_ready = 1'b0;
        set_cfg('0, 1'b0, 0);

        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_valid", 128'(bus.out_valid), 128'(0));
        chk("reset_addr", 128'(bus.out_addr), 128'(0));
        chk("reset_data", bus.out_data, 128'(0));
        chk("reset_busy", 128'(bus.busy), 128'(0));
        chk("reset_done", 128'(bus.drain_done), 128'(0));
        chk("reset_conflict", 128'(bus.acc_conflict), 128'(0));
        rst_n = 1'b1;
        tick();

        for (int a = 0; a < 16; a++) begin
            for (int i = 0; i < LANES; i++)
                d[i*32 +: 32] = (i % 2 == 1) ? $urandom : 32'($urandom_range(2000)) - 32'd1000;
            acc_beat(a, 1'b1, d);
        end
        acc_idle();

        // clear then two back-to-back accumulates to the same entry
        acc_beat(5, 1'b1, splat(100));
        acc_beat(5, 1'b0, splat(7));
        acc_beat(5, 1'b0, splat(7));
        acc_idle();
        drain(6, -1, 0, -1, 1'b0, 1'b0, 0, '0);
        for (int i = 0; i < LANES; i++) chk("clr_acc_114", 128'(cap[5][i*8 +: 8]), 128'(8'd114));

        // rounding and saturation
        d = '0;
        d[0 +: 32] = 32'd300; d[32 +: 32] = -32'sd300; d[64 +: 32] = 32'd5; d[96 +: 32] = -32'sd5;
        acc_beat(1, 1'b1, d);
        acc_beat(2, 1'b1, splat(1000));
        acc_beat(3, 1'b1, splat(-50));
        acc_idle();
        set_cfg('0, 1'b0, 1);
        drain(2, -1, 0, -1, 1'b0, 1'b0, 0, '0);
        chk("sat_pos", 128'(cap[1][7:0]), 128'(8'h7F));
        chk("sat_neg", 128'(cap[1][15:8]), 128'(8'h80));
        chk("round_pos", 128'(cap[1][23:16]), 128'(8'h03));
        chk("round_neg", 128'(cap[1][31:24]), 128'(8'hFE));
        set_cfg('0, 1'b0, 3);
        drain(3, -1, 0, -1, 1'b0, 1'b0, 0, '0);
        chk("shift3_125", 128'(cap[2][7:0]), 128'(8'd125));

        // bias with and without ReLU
        set_cfg(splat(20), 1'b1, 0);
        drain(4, -1, 0, -1, 1'b0, 1'b0, 0, '0);
        chk("relu_zero", cap[3], 128'(0));
        set_cfg(splat(20), 1'b0, 0);
        drain(4, -1, 0, -1, 1'b0, 1'b0, 0, '0);
        chk("bias_minus30", 128'(cap[3][7:0]), 128'(8'hE2));

        // backpressure on beat 1
        for (int i = 0; i < LANES; i++) b[i*32 +: 32] = 32'($urandom_range(400)) - 32'd200;
        set_cfg(b, 1'b0, 4);
        drain(3, 1, 4, -1, 1'b0, 1'b0, 0, '0);

        // accumulate and drain_start while busy are both dropped
        chk("conflict_before", 128'(bus.acc_conflict), 128'(0));
        drain(3, -1, 0, -1, 1'b1, 1'b0, 0, '0);
        chk("conflict_sticky", 128'(bus.acc_conflict), 128'(1));
        drain(3, -1, 0, -1, 1'b0, 1'b0, 0, '0);

        // empty drain
        drain(0, -1, 0, -1, 1'b0, 1'b0, 0, '0);

        // accumulate in the same cycle as drain_start is seen by LOAD
        for (int i = 0; i < LANES; i++) d[i*32 +: 32] = $urandom;
        set_cfg(b, 1'b0, 20);
        drain(4, -1, 0, -1, 1'b0, 1'b1, 0, d);

        // reset in the middle of a drain, then a clean drain of the same data
        set_cfg(b, 1'b0, 2);
        drain(10, -1, 0, 2, 1'b0, 1'b0, 0, '0);
        chk("conflict_cleared", 128'(bus.acc_conflict), 128'(0));
        drain(10, -1, 0, -1, 1'b0, 1'b0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
